// File: rtl/n0_prime_pkg.sv
// Shared constants and FSM encoding for the RSA-CRT precompute block (qinv and n0').
package n0_prime_pkg;

   localparam int W            = 32;
   localparam int NEWTON_ITERS = 5;

   typedef enum logic [2:0] {
      IDLE,
      INIT,
      DIV,
      UPD,
      FIX,
      NINV,
      DONE
   } state_t;

endpackage

// File: rtl/n0_prime_if.sv
// Key-load handshake: primes in, CRT coefficient and Montgomery constant out.
interface n0_prime_if;
   import n0_prime_pkg::*;

   logic         start;
   logic [W-1:0] p;
   logic [W-1:0] q;
   logic [W-1:0] qinv;
   logic [W-1:0] t;
   logic         done;
   logic         err;

   modport master (output start, p, q, input qinv, t, done, err);
   modport slave  (input start, p, q, output qinv, t, done, err);

endinterface

// File: rtl/n0_prime_div.sv
// Sequential restoring unsigned divider: one quotient bit per cycle, W cycles per division.
module n0_prime_div
   import n0_prime_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         go,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] quo,
   output logic [W-1:0] rem,
   output logic         ready
);

   localparam int CW = $clog2(W + 1);

   logic [CW-1:0] cnt;
   logic [W-1:0]  dvs;
   logic [W:0]    shifted;
   logic [W:0]    diff;

   // NOTE: always_comb uses blocking assignments and gives every output a value on every path, so no latch is inferred.
   always_comb begin
      shifted = {rem, quo[W-1]};
      diff    = shifted - {1'b0, dvs};
   end

   // quo doubles as the dividend shift register; diff[W] is the borrow of the trial subtraction.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         quo   <= '0;
         rem   <= '0;
         dvs   <= '0;
         cnt   <= '0;
         ready <= 1'b0;
      end else if (go) begin
         quo   <= dividend;
         rem   <= '0;
         dvs   <= divisor;
         cnt   <= CW'(W);
         ready <= 1'b0;
      end else if (cnt != '0) begin
         if (!diff[W]) begin
            rem <= diff[W-1:0];
            quo <= {quo[W-2:0], 1'b1};
         end else begin
            rem <= shifted[W-1:0];
            quo <= {quo[W-2:0], 1'b0};
         end
         cnt <= cnt - CW'(1);
         if (cnt == CW'(1)) ready <= 1'b1;
      end
   end

endmodule

// File: rtl/n0_prime.sv
// RSA-CRT precompute: qinv = q^-1 mod p via extended Euclid, t = -(p*q)^-1 mod 2^W via Newton.
module n0_prime
   import n0_prime_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   n0_prime_if.slave  bus
);

   state_t              state;
   logic                start_d;
   logic [W-1:0]        p_l, q_l;
   logic signed [W:0]   r0, r1, s0, s1;
   logic                bad_p, job_err, div_go;
   logic [W-1:0]        n_r, x_r, y_r;
   logic [2:0]          it;
   logic                ph;
   logic [W-1:0]        qinv_r, t_r;
   logic                done_r, err_r;

   logic [W-1:0]        div_quo, div_rem;
   logic                div_ready;
   logic signed [2*W+1:0] prod;
   logic signed [W:0]   s_next, s_fix;
   logic [W-1:0]        n_comb;

   n0_prime_div u_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .go       (div_go),
      .dividend (r0[W-1:0]),
      .divisor  (r1[W-1:0]),
      .quo      (div_quo),
      .rem      (div_rem),
      .ready    (div_ready)
   );

   // Bezout coefficients stay within +-p, so the W+1-bit truncation of the product is exact.
   always_comb begin
      prod   = $signed({1'b0, div_quo}) * s1;
      s_next = s0 - $signed(prod[W:0]);
      s_fix  = s0[W] ? s0 + $signed({1'b0, p_l}) : s0;
      n_comb = p_l * q_l;
   end

   // NOTE: sequential state is updated with non-blocking assignments only; the datapath registers are reset as well so an aborted job leaves nothing behind.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         start_d <= 1'b0;
         p_l     <= '0;
         q_l     <= '0;
         r0      <= '0;
         r1      <= '0;
         s0      <= '0;
         s1      <= '0;
         bad_p   <= 1'b0;
         job_err <= 1'b0;
         div_go  <= 1'b0;
         n_r     <= '0;
         x_r     <= '0;
         y_r     <= '0;
         it      <= '0;
         ph      <= 1'b0;
         qinv_r  <= '0;
         t_r     <= '0;
         done_r  <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         start_d <= bus.start;
         div_go  <= 1'b0;
         case (state)
            IDLE: if (bus.start && !start_d) begin
               p_l    <= bus.p;
               q_l    <= bus.q;
               done_r <= 1'b0;
               err_r  <= 1'b0;
               state  <= INIT;
            end
            INIT: begin
               r0    <= $signed({1'b0, p_l});
               r1    <= $signed({1'b0, q_l});
               s0    <= '0;
               s1    <= (W+1)'(1);
               bad_p <= (p_l < W'(2));
               // q==0 means gcd is already p; skip the divider rather than divide by zero.
               if (p_l < W'(2) || q_l == '0) begin
                  state <= FIX;
               end else begin
                  div_go <= 1'b1;
                  state  <= DIV;
               end
            end
            DIV: if (!div_go && div_ready) state <= UPD;
            UPD: begin
               r0 <= r1;
               r1 <= $signed({1'b0, div_rem});
               s0 <= s1;
               s1 <= s_next;
               if (div_rem != '0) begin
                  div_go <= 1'b1;
                  state  <= DIV;
               end else begin
                  state  <= FIX;
               end
            end
            FIX: begin
               if (!bad_p && r0 == (W+1)'(1)) begin
                  qinv_r  <= s_fix[W-1:0];
                  job_err <= 1'b0;
               end else begin
                  qinv_r  <= '0;
                  job_err <= 1'b1;
               end
               n_r   <= n_comb;
               x_r   <= n_comb;
               it    <= '0;
               ph    <= 1'b0;
               state <= NINV;
            end
            NINV: begin
               // x = n is already correct to 3 bits; each iteration doubles that.
               if (!n_r[0]) begin
                  t_r   <= '0;
                  state <= DONE;
               end else if (it == 3'(NEWTON_ITERS)) begin
                  t_r   <= -x_r;
                  state <= DONE;
               end else if (!ph) begin
                  y_r <= n_r * x_r;
                  ph  <= 1'b1;
               end else begin
                  x_r <= x_r * (W'(2) - y_r);
                  ph  <= 1'b0;
                  it  <= it + 3'd1;
               end
            end
            DONE: begin
               done_r <= 1'b1;
               err_r  <= job_err;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.qinv = qinv_r;
   assign bus.t    = t_r;
   assign bus.done = done_r;
   assign bus.err  = err_r;

endmodule

// File: tb/tb_n0_prime.sv
// Directed bench for n0_prime: reset, CRT coefficient / n0' results, error cases, busy-start and abort.
module tb_n0_prime;

   logic clk;
   logic rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;

   n0_prime_if bus ();

   n0_prime dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // start held high two cycles, then wait (bounded) for done
   task automatic run_job(input logic [31:0] pv, input logic [31:0] qv, input string tag);
      int cyc;
      @(negedge clk);
      bus.p     = pv;
      bus.q     = qv;
      bus.start = 1'b1;
      @(negedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      cyc = 2;
      while (!bus.done && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, "_done"}, {31'b0, bus.done}, 32'd1);
   endtask

   initial begin
      logic [31:0] nt;
      int          rises;
      logic        prev;

      // 1. reset, with start asserted during reset
      rst_n     = 1'b0;
      bus.start = 1'b1;
      bus.p     = 32'd7;
      bus.q     = 32'd3;
      repeat (2) @(negedge clk);
      check("rst_qinv", bus.qinv, 32'd0);
      check("rst_t",    bus.t,    32'd0);
      check("rst_done", {31'b0, bus.done}, 32'd0);
      check("rst_err",  {31'b0, bus.err},  32'd0);
      bus.start = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("rst_nojob", {31'b0, bus.done}, 32'd0);

      // 2. main vector
      run_job(32'h1EEF, 32'h189D, "v7919");
      check("v7919_qinv", bus.qinv, 32'h25A);
      check("v7919_err",  {31'b0, bus.err}, 32'd0);
      nt = 32'h02F96093 * bus.t;
      check("v7919_nt", nt, 32'hFFFFFFFF);

      // 3. small primes, q > p
      run_job(32'd7, 32'd3, "v7_3");
      check("v7_3_qinv", bus.qinv, 32'd5);
      check("v7_3_err",  {31'b0, bus.err}, 32'd0);

      run_job(32'd11, 32'd25, "v11_25");
      check("v11_25_qinv", bus.qinv, 32'd4);
      check("v11_25_err",  {31'b0, bus.err}, 32'd0);
      nt = 32'd275 * bus.t;
      check("v11_25_nt", nt, 32'hFFFFFFFF);

      // 4. error cases
      run_job(32'd5, 32'd10, "v5_10");
      check("v5_10_err",  {31'b0, bus.err}, 32'd1);
      check("v5_10_qinv", bus.qinv, 32'd0);
      check("v5_10_t",    bus.t,    32'd0);

      run_job(32'd1, 32'd3, "v1_3");
      check("v1_3_err",  {31'b0, bus.err}, 32'd1);
      check("v1_3_qinv", bus.qinv, 32'd0);

      run_job(32'd7, 32'd0, "v7_0");
      check("v7_0_err",  {31'b0, bus.err}, 32'd1);
      check("v7_0_qinv", bus.qinv, 32'd0);
      check("v7_0_t",    bus.t,    32'd0);

      // 5. second start while busy, inputs changed mid-job
      @(negedge clk);
      bus.p     = 32'h1EEF;
      bus.q     = 32'h189D;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (10) @(negedge clk);
      bus.start = 1'b1;
      bus.p     = 32'd11;
      bus.q     = 32'd25;
      repeat (3) @(negedge clk);
      bus.start = 1'b0;
      rises = 0;
      prev  = bus.done;
      for (int i = 0; i < 2500; i++) begin
         @(negedge clk);
         if (bus.done && !prev) rises++;
         prev = bus.done;
      end
      check("busy_rises", 32'(rises), 32'd1);
      check("busy_qinv",  bus.qinv, 32'h25A);
      check("busy_err",   {31'b0, bus.err}, 32'd0);
      nt = 32'h02F96093 * bus.t;
      check("busy_nt", nt, 32'hFFFFFFFF);

      // 6. reset mid-job, then a clean job
      @(negedge clk);
      bus.p     = 32'd7;
      bus.q     = 32'd3;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_qinv", bus.qinv, 32'd0);
      check("abort_t",    bus.t,    32'd0);
      check("abort_done", {31'b0, bus.done}, 32'd0);
      check("abort_err",  {31'b0, bus.err},  32'd0);
      rst_n = 1'b1;
      run_job(32'd11, 32'd25, "post");
      check("post_qinv", bus.qinv, 32'd4);
      check("post_err",  {31'b0, bus.err}, 32'd0);
      nt = 32'd275 * bus.t;
      check("post_nt", nt, 32'hFFFFFFFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
